// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: occupancy states, counter
// width and the standard control/data widths of each pipeline boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int STALL_CNT_W = 16;

  // Boundary widths: control = WB/M/EX bits, data = carried payload.
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 111;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a two-entry skid buffer, flush and bubble
// masking of control bits. Define PIPE_STALL_CNT_EN to build the stall counter.
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// valid never depends combinationally on ready; in_ready and out_valid are
// flop outputs, so no path exists from out_ready to in_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 5,
  parameter int                DATA_W   = 69,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output pipe_state_e            dbg_state
);

  pipe_state_e       state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              accept;
  logic              drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // in_ready/out_valid are kept as their own flops rather than decoded from state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= CTRL_RST;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
      skid_data_q <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept && drain) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (accept) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= ST_FULL;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            in_ready_q  <= 1'b1;
            state_q     <= ST_HALF;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = out_valid_q ? main_ctrl_q : CTRL_RST;
  assign out_data  = main_data_q;
  assign dbg_state = state_q;

`ifdef PIPE_STALL_CNT_EN
  pipe_sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .clear (1'b0),
    .count (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic; the stall-counter expectation
// follows PIPE_STALL_CNT_EN.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int CTRL_W = 5;
  localparam int DATA_W = 69;
  localparam int ENT_W  = CTRL_W + DATA_W;
  localparam logic [CTRL_W-1:0] CTRL_RST = '0;
`ifdef PIPE_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      in_ctrl;
  logic [DATA_W-1:0]      in_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [DATA_W-1:0]      out_data;
  logic [STALL_CNT_W-1:0] stall_cnt;
  pipe_state_e            dbg_state;

  logic [ENT_W-1:0]       exp_q[$];
  logic [STALL_CNT_W-1:0] exp_stall;
  int                     n_checks;
  int                     n_errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  pipe_stage_elastic #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CTRL_RST(CTRL_RST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // One clock: scoreboard the handshakes that will occur at the next edge,
  // then step to just after that edge.
  task automatic tick();
    logic [ENT_W-1:0] exp;
    bit acc;
    bit drn;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    n_checks++;
    if (stall_cnt !== exp_stall) begin
      n_errors++;
      $display("FAIL stall_cnt: got %0h expected %0h", stall_cnt, exp_stall);
    end
    if (!out_valid) begin
      n_checks++;
      if (out_ctrl !== CTRL_RST) begin
        n_errors++;
        $display("FAIL bubble_ctrl: got %b expected %b", out_ctrl, CTRL_RST);
      end
    end
    if (drn) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_out: got ctrl=%b data=%0h expected nothing", out_ctrl, out_data);
      end else begin
        exp = exp_q.pop_front();
        if ({out_ctrl, out_data} !== exp) begin
          n_errors++;
          $display("FAIL out_entry: got ctrl=%b data=%0h expected ctrl=%b data=%0h",
                   out_ctrl, out_data, exp[ENT_W-1 -: CTRL_W], exp[DATA_W-1:0]);
        end
      end
    end
    if (flush) exp_q.delete();
    else if (acc) exp_q.push_back({in_ctrl, in_data});
    if (STALL_EN && out_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d entries still expected, 0 required", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b0; exp_stall = '0;
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== CTRL_RST ||
        stall_cnt !== '0 || dbg_state !== ST_EMPTY) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b r=%b ctrl=%b cnt=%0h st=%0d expected 0 1 0 0 0",
               out_valid, in_ready, out_ctrl, stall_cnt, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = CTRL_W'($urandom_range(0, 31));
      in_data  = DATA_W'(i);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_ready: got %b expected 1 at beat %0d", in_ready, i);
      end
      if (i > 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(i - 1)) begin
          n_errors++;
          $display("FAIL stream_out: got v=%b data=%0h expected v=1 data=%0h", out_valid, out_data, i - 1);
        end
      end
      tick();
    end
    drain_all(4);
  endtask

  task automatic test_backpressure();
    bit a;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 5'b00001; in_data = DATA_W'('hA); tick();
    in_ctrl   = 5'b00010; in_data = DATA_W'('hB); tick();
    n_checks++;
    if (dbg_state !== ST_FULL || in_ready !== 1'b0 || out_data !== DATA_W'('hA)) begin
      n_errors++;
      $display("FAIL bp_full: got st=%0d r=%b data=%0h expected st=2 r=0 data=a", dbg_state, in_ready, out_data);
    end
    in_ctrl = 5'b00100; in_data = DATA_W'('hC);
    repeat (2) tick();
    out_ready = 1'b1;
    for (int k = 0; k < 6 && in_valid; k++) begin
      a = in_ready;
      tick();
      if (a) in_valid = 1'b0;
    end
    n_checks++;
    if (in_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_accept_c: in_ready got %b expected 1 within budget", in_ready);
    end
    drain_all(4);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_ctrl = 5'b00101; in_data = DATA_W'('h5);
    tick();
    flush   = 1'b1;
    in_ctrl = 5'b00110; in_data = DATA_W'('h6);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== CTRL_RST || in_ready !== 1'b1 || dbg_state !== ST_EMPTY) begin
      n_errors++;
      $display("FAIL flush_empty: got v=%b ctrl=%b r=%b st=%0d expected 0 0 1 0", out_valid, out_ctrl, in_ready, dbg_state);
    end
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_ctrl = 5'b11111;
    in_data   = DATA_W'({$urandom(), $urandom(), $urandom()});
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_ctrl !== 5'b11111) begin
      n_errors++;
      $display("FAIL bubble_held: got %b expected 11111", out_ctrl);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 5'b00000) begin
      n_errors++;
      $display("FAIL bubble_mask: got v=%b ctrl=%b expected 0 00000", out_valid, out_ctrl);
    end
  endtask

  task automatic test_reset_mid_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_ctrl = CTRL_W'($urandom_range(1, 31));
      in_data = DATA_W'({$urandom(), $urandom(), $urandom()});
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (dbg_state !== ST_FULL) begin
      n_errors++;
      $display("FAIL rst_fill: got st=%0d expected 2", dbg_state);
    end
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    exp_stall = '0;
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 5'b00000 || in_ready !== 1'b1 || stall_cnt !== '0) begin
      n_errors++;
      $display("FAIL rst_async: got v=%b ctrl=%b r=%b cnt=%0h expected 0 0 1 0", out_valid, out_ctrl, in_ready, stall_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; in_ctrl = 5'b10011; in_data = DATA_W'(1); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 5'b10011 || out_data !== DATA_W'(1)) begin
      n_errors++;
      $display("FAIL rst_first: got v=%b ctrl=%b data=%0h expected 1 10011 1", out_valid, out_ctrl, out_data);
    end
    drain_all(4);
  endtask

  task automatic test_stall_cnt();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_ctrl = 5'b01010; in_data = DATA_W'('h77);
    tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    n_checks++;
    if (stall_cnt !== (STALL_EN ? 16'hFFFF : 16'h0000)) begin
      n_errors++;
      $display("FAIL stall_sat: got %0h expected %0h", stall_cnt, STALL_EN ? 16'hFFFF : 16'h0000);
    end
    drain_all(4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_mid_full();
    test_stall_cnt();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, flow-controlled pipeline register for any inter-stage boundary: IF/ID, ID/EX, EX/MEM or MEM/WB.
- Carries a control field and a data field with valid/ready handshakes on both sides.
- A two-entry skid buffer keeps in_ready a registered signal, so downstream stalls never form a combinational path upstream.
- Adds flush (bubble insertion) and gates control bits to zero on bubbles, so MemWrite/RegWrite-style bits never fire on invalid slots.

Parameters:
- CTRL_W, 5, width of the control field (WB/M bits); masked to 0 when the output is not valid.
- DATA_W, 69, width of the data payload (e.g. ALU result 32 + store data 32 + dest reg 5); not masked.
- CTRL_RST, 0, reset/bubble value of the control field, CTRL_W bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream slot valid
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- flush  in  1  discard all held entries at next edge
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  main entry ctrl when out_valid, else CTRL_RST
- out_data  out  DATA_W  main entry payload; value undefined-but-stable when !out_valid
- stall_cnt  out  16  stall cycle counter (see Optional Feature)

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State: EMPTY (none held), HALF (main only), FULL (main+skid).
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = (state != FULL), from a flop.
- EMPTY: accept -> main <= in, go HALF.
- HALF, accept & drain: main <= in, stay HALF.
- HALF, accept & !drain: skid <= in, go FULL.
- HALF, !accept & drain: go EMPTY.
- FULL: no accept possible. On drain, main <= skid, go HALF.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput is 1 per cycle with out_ready held high.
- Ordering: strict FIFO order; no entry dropped or duplicated except by flush.
- flush (highest priority): next state EMPTY. An accept in the same cycle is discarded, and a drain in the same cycle still completes downstream. in_ready is 1 the cycle after flush.
- Reset (async, any time, including mid-transfer): state EMPTY; out_valid 0; in_ready 1; out_ctrl = CTRL_RST; main/skid data 0; stall_cnt 0.
- Reset release is synchronous to clk. The first accept can occur on the first edge after release.
- out_ctrl = CTRL_RST whenever out_valid = 0, regardless of stored bits.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle with out_valid & !out_ready. It saturates at 16'hFFFF and is cleared by reset only; flush does not clear it.
- Not defined: no counter logic; stall_cnt tied to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_HALF, ST_FULL);
  - STALL_CNT_W = 16;
  - the standard CTRL_W/DATA_W constants for each pipeline boundary (e.g. EXMEM_CTRL_W = 5, EXMEM_DATA_W = 69).
- One natural sub-module: pipe_sat_counter (saturating counter, width parameter, inc/clear), instantiated only under PIPE_STALL_CNT_EN.

Test Plan:
- Reset mid-FULL:
  - Stimulus: fill both entries, assert reset asynchronously between edges.
  - Required response: out_valid = 0 and out_ctrl = 0 immediately; in_ready = 1; after release, the first accepted ctrl = 5'b10011 / data = 69'h1 appears 1 cycle later.
- Streaming:
  - Stimulus: out_ready = 1, in_valid = 1 for 8 cycles, data = 1..8.
  - Required response: out_data = 1..8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready = 0, push data 0xA then 0xB.
  - Required response: state FULL, in_ready = 0 the next cycle, third push 0xC held by upstream. On out_ready = 1, output order is 0xA, 0xB, 0xC with no loss.
- Flush with simultaneous accept:
  - Stimulus: state HALF holding 0x5; flush = 1 and in_valid = 1 with 0x6.
  - Required response: next cycle out_valid = 0 and out_ctrl = CTRL_RST; neither 0x5 nor 0x6 ever appears.
- Bubble masking:
  - Stimulus: stored ctrl = 5'b11111, then drain with no new input.
  - Required response: out_valid = 0 and out_ctrl = 0.
- Stall counter (with PIPE_STALL_CNT_EN):
  - Stimulus: hold out_valid = 1, out_ready = 0 for 70000 cycles.
  - Required response: stall_cnt = 16'hFFFF.
  - Without the macro: stall_cnt = 0 throughout.
